// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 : core load/store path
//   port 1 : debug / DMA loader
// Round-robin arbitration with one access per grant. Writes finish at the
// grant edge, so writes can go back to back. A read parks the arbiter in
// RD_WAIT for one cycle while the memory's registered read data arrives. That
// data is then handed to the owning port with a one-cycle rvalid pulse.
//
// Optional feature (macro DMEM_ARB_ADDR_CHECK_EN):
//   Any access with addr >= DEPTH is still granted, but the memory is not
//   touched. errN pulses in the cycle after the grant. Without the macro,
//   err0/err1 stay 0 and addresses pass straight through.
//
// Parameters:
//   DEPTH  number of DW-bit words in the memory (valid addresses 0..DEPTH-1)
//   AW     address width
//   DW     data width
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req0/1, wr0/1           request (held until granted), 1 = write
//   addr0/1, wdata0/1       word address and write data of each requester
//   gnt0/1                  combinational grant (accepted when req & gnt)
//   rvalid0/1, rdata0/1     registered read response
//   err0/1                  registered out-of-range error pulse
//   mem_addr, mem_wr,
//   mem_rd, mem_wr_data     memory command pins
//   mem_rd_data             memory read data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t        state, state_next;
  logic          last_grant, last_grant_next;
  logic          owner, owner_next;

  // Arbitration result for the current cycle
  logic          any_gnt;
  logic          sel_port;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          addr_ok;

  always_comb begin
    any_gnt  = 1'b0;
    sel_port = 1'b0;
    if (state == IDLE) begin
      if (req0 && req1) begin
        any_gnt  = 1'b1;
        sel_port = ~last_grant;   // alternate on contention
      end else if (req0) begin
        any_gnt  = 1'b1;
        sel_port = 1'b0;
      end else if (req1) begin
        any_gnt  = 1'b1;
        sel_port = 1'b1;
      end
    end
  end

  assign sel_wr    = sel_port ? wr1    : wr0;
  assign sel_addr  = sel_port ? addr1  : addr0;
  assign sel_wdata = sel_port ? wdata1 : wdata0;

  // When the check is disabled every address counts as in range.
  assign addr_ok = !CHECK_EN || (sel_addr < AW'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // port 0 wins the first contention
      owner      <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      owner      <= owner_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    owner_next      = owner;
    case (state)
      IDLE: begin
        if (any_gnt) begin
          last_grant_next = sel_port;
          // Only an in-range read waits for data. Writes and rejected
          // accesses finish at the grant edge.
          if (!sel_wr && addr_ok) begin
            state_next = RD_WAIT;
            owner_next = sel_port;
          end
        end
      end
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic (memory command and grants)
  always_comb begin
    gnt0        = any_gnt && !sel_port;
    gnt1        = any_gnt &&  sel_port;
    mem_wr      = any_gnt &&  sel_wr && addr_ok;
    mem_rd      = any_gnt && !sel_wr && addr_ok;
    mem_addr    = any_gnt ? sel_addr  : '0;
    mem_wr_data = any_gnt ? sel_wdata : '0;
  end

  // Response registers: read data arrives during RD_WAIT and is presented to
  // the owner one cycle later. The non-owner's rdata holds its value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      rvalid0 <= (state == RD_WAIT) && !owner;
      rvalid1 <= (state == RD_WAIT) &&  owner;
      if (state == RD_WAIT && !owner) rdata0 <= mem_rd_data;
      if (state == RD_WAIT &&  owner) rdata1 <= mem_rd_data;
      err0    <= CHECK_EN && gnt0 && !addr_ok;
      err1    <= CHECK_EN && gnt1 && !addr_ok;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural memory sits on the mem_*
// pins. A transaction-level reference model predicts every output in every
// cycle. The model keeps the memory contents, the last granted port and the
// single outstanding read response. Directed scenarios come first, followed
// by randomized traffic.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int DEPTH = 32;
  localparam int AW    = 64;
  localparam int DW    = 64;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_wr, mem_rd;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with a registered read. Addresses wrap.
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (mem_rd) mem_rd_data <= mem_arr[int'(mem_addr % 64'(DEPTH))];
    if (mem_wr) mem_arr[int'(mem_addr % 64'(DEPTH))] = mem_wr_data;
  end

  // Reference model state
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] exp_rdata [2];
  logic [DW-1:0] resp_data;
  int            cyc, last, busy_cyc, resp_cyc, resp_port, err_cyc, err_port;

  // Pending request of each requester, held until granted
  bit            p_req [2];
  bit            p_wr  [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  task automatic check_outputs(input bit e_g0, input bit e_g1, input bit e_mwr,
                               input bit e_mrd, input logic [AW-1:0] e_ma,
                               input logic [DW-1:0] e_wd, input bit e_rv0,
                               input bit e_rv1, input bit e_er0, input bit e_er1);
    check_eq("gnt0", 64'(gnt0), 64'(e_g0));
    check_eq("gnt1", 64'(gnt1), 64'(e_g1));
    check_eq("mem_wr", 64'(mem_wr), 64'(e_mwr));
    check_eq("mem_rd", 64'(mem_rd), 64'(e_mrd));
    check_eq("mem_addr", mem_addr, e_ma);
    check_eq("mem_wr_data", mem_wr_data, e_wd);
    check_eq("rvalid0", 64'(rvalid0), 64'(e_rv0));
    check_eq("rvalid1", 64'(rvalid1), 64'(e_rv1));
    check_eq("rdata0", rdata0, exp_rdata[0]);
    check_eq("rdata1", rdata1, exp_rdata[1]);
    check_eq("err0", 64'(err0), 64'(e_er0));
    check_eq("err1", 64'(err1), 64'(e_er1));
  endtask

  function automatic void model_reset();
    last      = 1;
    busy_cyc  = -10;
    resp_cyc  = -10;
    err_cyc   = -10;
    resp_port = 0;
    err_port  = 0;
    resp_data = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endfunction

  // Called just after a rising edge. Runs one clock cycle with reset held low
  // and checks the reset values of all outputs.
  task automatic apply_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs(0, 0, 0, 0, '0, '0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc++;
    reset_n = 1'b1;
  endtask

  // Called just after a rising edge. Drives one cycle and checks it against
  // the model.
  task automatic step();
    bit            any, in_rng, rv0, rv1;
    int            gp, idx;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_wd;
    req0 = p_req[0]; wr0 = p_wr[0]; addr0 = p_addr[0]; wdata0 = p_data[0];
    req1 = p_req[1]; wr1 = p_wr[1]; addr1 = p_addr[1]; wdata1 = p_data[1];
    @(negedge clk);
    any = 0;
    gp  = 0;
    if (cyc != busy_cyc) begin
      if (p_req[0] && p_req[1]) begin any = 1; gp = (last == 0) ? 1 : 0; end
      else if (p_req[0])        begin any = 1; gp = 0; end
      else if (p_req[1])        begin any = 1; gp = 1; end
    end
    in_rng = !CHK || (p_addr[gp] < 64'(DEPTH));
    idx    = int'(p_addr[gp] % 64'(DEPTH));
    e_ma   = any ? p_addr[gp] : '0;
    e_wd   = any ? p_data[gp] : '0;
    rv0    = (resp_cyc == cyc) && (resp_port == 0);
    rv1    = (resp_cyc == cyc) && (resp_port == 1);
    if (resp_cyc == cyc) exp_rdata[resp_port] = resp_data;
    check_outputs(any && gp == 0, any && gp == 1,
                  any && p_wr[gp] && in_rng, any && !p_wr[gp] && in_rng,
                  e_ma, e_wd, rv0, rv1,
                  (err_cyc == cyc) && (err_port == 0),
                  (err_cyc == cyc) && (err_port == 1));
    if (any) begin
      $display("cyc=%0d grant port=%0d %s addr=%0d data=%h", cyc, gp,
               p_wr[gp] ? "wr" : "rd", p_addr[gp], p_data[gp]);
      last = gp;
      if (!in_rng) begin
        err_cyc  = cyc + 1;
        err_port = gp;
      end else if (p_wr[gp]) begin
        gold[idx] = p_data[gp];
      end else begin
        resp_cyc  = cyc + 2;
        resp_port = gp;
        resp_data = gold[idx];
        busy_cyc  = cyc + 1;
      end
      p_req[gp] = 1'b0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic set_req(input int p, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    p_req[p] = 1'b1; p_wr[p] = w; p_addr[p] = a; p_data[p] = d;
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = DW'(i * 11);
      gold[i]    = DW'(i * 11);
    end
    for (int i = 0; i < 2; i++) set_req(i, 0, '0, '0);
    for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Write then read back on port 0
    set_req(0, 1, 64'd5, 64'hA5);
    step();
    set_req(0, 0, 64'd5, '0);
    repeat (3) step();

    // Both ports reading continuously after reset: alternating grants
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      if (!p_req[0]) set_req(0, 0, 64'd1, '0);
      if (!p_req[1]) set_req(1, 0, 64'd2, '0);
      step();
    end
    for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
    repeat (3) step();

    // Four back-to-back writes on port 1, then a read of the same word
    for (int k = 1; k <= 4; k++) begin
      set_req(1, 1, 64'd3, DW'(k));
      step();
    end
    set_req(1, 0, 64'd3, '0);
    repeat (3) step();

    // Port 1 read, port 0 arrives during RD_WAIT
    set_req(1, 0, 64'd7, '0);
    step();
    set_req(0, 0, 64'd8, '0);
    repeat (4) step();

    // Reset while in RD_WAIT, then contention goes to port 0
    set_req(1, 0, 64'd2, '0);
    step();
    apply_reset();
    step();
    set_req(0, 0, 64'd4, '0);
    set_req(1, 0, 64'd6, '0);
    repeat (5) step();

    // Out-of-range read on port 0
    set_req(0, 0, 64'd32, '0);
    repeat (3) step();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && $urandom_range(0, 99) < 60) begin
          if ($urandom_range(0, 9) == 0)
            set_req(i, 1'($urandom_range(0, 1)), 64'(DEPTH + $urandom_range(0, 100)),
                    {$urandom, $urandom});
          else
            set_req(i, 1'($urandom_range(0, 1)), 64'($urandom_range(0, DEPTH - 1)),
                    {$urandom, $urandom});
        end
      end
      step();
    end
    for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store path) and port 1 (debug/DMA loader).
- Round-robin grant, one access per grant.
- Sequences the memory's 1-cycle registered read latency and returns read data to the owning port with a registered valid pulse.
- Sits between the requesters and the data memory; drives that memory's addr, mem_wr, mem_rd and wr_data pins and consumes its rd_data.

Parameters:
- DEPTH, 32, number of 64-bit words in the data memory; valid word addresses are 0..DEPTH-1.
- AW, 64, address width of requester and memory address ports.
- DW, 64, data width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req0 / req1  in  1  access request, held until granted.
- wr0 / wr1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational grant; the access is accepted in a cycle where req and gnt are both high.
- rvalid0 / rvalid1  out  1  registered 1-cycle read-response pulse.
- rdata0 / rdata1  out  DW  read data, valid with rvalid.
- err0 / err1  out  1  registered 1-cycle error pulse (optional feature only; tied 0 otherwise).
- mem_addr  out  AW  to memory addr.
- mem_wr  out  1  to memory mem_wr.
- mem_rd  out  1  to memory mem_rd.
- mem_wr_data  out  DW  to memory wr_data.
- mem_rd_data  in  DW  from memory rd_data; valid the cycle after mem_rd.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, last_grant = 1 (so port 0 wins first).
  - rvalid0/1 = 0, rdata0/1 = 0, err0/1 = 0.
  - Combinational outputs in IDLE with no req: gnt = 0, mem_wr = 0, mem_rd = 0, mem_addr = 0, mem_wr_data = 0.
- FSM states: IDLE, RD_WAIT.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - Granted port drives mem_addr/mem_wr_data. mem_wr = wr, mem_rd = !wr, same cycle.
  - Update last_grant on every grant.
  - Write: completes at that clock edge; stay in IDLE, so back-to-back writes are possible every cycle.
  - Read: record owner, go to RD_WAIT.
- RD_WAIT:
  - No grants; all mem_* controls 0.
  - Capture mem_rd_data into rdata<owner>.
  - Pulse rvalid<owner> in the following cycle; return to IDLE.
  - That following cycle may already grant a new access.
- Read latency: grant at cycle T, rvalid high at T+2. Maximum read throughput is 1 per 2 cycles.
- Write latency: the write is visible to a read granted at T+1 (memory write at edge T).
- Non-owner rdata holds its previous value; rvalid is never high on both ports in the same cycle.
- Requester changing req/addr while not granted: no effect, no state change.
- Reset mid-read (in RD_WAIT): abort to IDLE, no rvalid issued, last_grant = 1.
- mem_wr and mem_rd are never both 1.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- Defined:
  - A granted access with addr >= DEPTH is still granted, but mem_wr = mem_rd = 0 (the memory is not touched).
  - errN pulses high in the cycle after the grant; rvalidN stays 0; FSM stays in IDLE.
  - last_grant updates as for a normal access.
- Undefined:
  - err0/err1 are tied 0 and addresses pass through unchecked.
  - The out-of-range behaviour is the memory's.

Test Plan:
- Reset then req0 write addr0=5, wdata0=64'hA5 -> gnt0 same cycle, mem_wr=1, mem_addr=5. Then req0 read addr 5 -> rvalid0 at T+2 with rdata0=64'hA5, rvalid1 stays 0.
- req0 and req1 both reading continuously from reset (addr 1 and 2, preloaded 11 and 22) -> grants alternate 0,1,0,1 starting with port 0. Responses are rvalid0/11, rvalid1/22 repeating, one grant every 2 cycles.
- req1 write addr 3 every cycle for 4 cycles with data 1..4 -> 4 consecutive gnt1 cycles, then a read of addr 3 returns 4.
- Port 1 read at T. req0 raised at T+1 -> no gnt0 at T+1 (RD_WAIT), gnt0 at T+2 coinciding with rvalid1.
- Assert reset_n low during RD_WAIT -> no rvalid pulse, state IDLE; the next simultaneous request is granted to port 0.
- With DMEM_ARB_ADDR_CHECK_EN: req0 read addr=32 -> gnt0, mem_rd=0, err0 pulse next cycle, no rvalid0. Without the macro, err0 stays 0.
